// File: rtl/lvdc_pkg.sv
// rtl/lvdc_pkg.sv - shared LVDC word width and accumulator op encoding
package lvdc_pkg;

    localparam int LVDC_WORD_W = 26;

    typedef enum logic [2:0] {
        ACC_HOLD = 3'd0,
        ACC_LOAD = 3'd1,
        ACC_ADD  = 3'd2,
        ACC_SUB  = 3'd3,
        ACC_AND  = 3'd4
    } acc_op_e;

    // Codes 5-7 are unassigned and behave as HOLD.
    function automatic acc_op_e decode_op(input logic [2:0] code);
        case (code)
            3'd1:    return ACC_LOAD;
            3'd2:    return ACC_ADD;
            3'd3:    return ACC_SUB;
            3'd4:    return ACC_AND;
            default: return ACC_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// rtl/serial_alu_bit.sv - combinational one-bit stage of the serial accumulator
module serial_alu_bit
    import lvdc_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    carry_in,
    input  acc_op_e op,
    output logic    r,
    output logic    carry_out
);

    logic b_eff;

    // Subtraction is a + ~b with the carry seeded to 1 at bit 0.
    assign b_eff = (op == ACC_SUB) ? ~b : b;

    always_comb begin
        r         = a;
        carry_out = 1'b0;
        case (op)
            ACC_LOAD: r = b;
            ACC_AND:  r = a & b;
            ACC_ADD, ACC_SUB: begin
                r         = a ^ b_eff ^ carry_in;
                carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
            end
            default:  r = a;
        endcase
    end

endmodule

// File: rtl/serial_accumulator.sv
// rtl/serial_accumulator.sv - bit-serial LSB-first accumulator with serial and parallel result
module serial_accumulator
    import lvdc_pkg::*;
#(
    parameter int W = LVDC_WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_en,
    input  logic         word_start,
    input  logic [2:0]   op,
    input  logic         ser_in,
    output logic         ser_out,
    output logic [W-1:0] acc_q,
    output logic         busy,
    output logic         word_done,
    output logic         acc_zero,
    output logic         acc_neg,
    output logic         ovf,
    output logic         sync_err
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state;
    acc_op_e       op_r;
    acc_op_e       op_cur;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] cnt_cur;
    logic          carry;
    logic          carry_cur;
    logic          zero_run;
    logic          zero_cur;
    logic          start;
    logic          step;
    logic          last;
    logic          r;
    logic          carry_out;

    assign start = bit_en & word_start;
    assign step  = bit_en & (start | (state == RUN));

    // A start strobe processes bit 0 itself, so it seeds the stage from op rather than the registers.
    always_comb begin
        op_cur    = op_r;
        carry_cur = carry;
        cnt_cur   = bit_cnt;
        zero_cur  = zero_run;
        if (start) begin
            op_cur    = decode_op(op);
            carry_cur = (decode_op(op) == ACC_SUB);
            cnt_cur   = '0;
            zero_cur  = 1'b1;
        end
    end

    assign last = (cnt_cur == LAST_BIT);

    serial_alu_bit u_alu (
        .a         (acc_q[0]),
        .b         (ser_in),
        .carry_in  (carry_cur),
        .op        (op_cur),
        .r         (r),
        .carry_out (carry_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_r      <= ACC_HOLD;
            bit_cnt   <= '0;
            carry     <= 1'b0;
            zero_run  <= 1'b1;
            acc_q     <= '0;
            word_done <= 1'b0;
            acc_zero  <= 1'b1;
            acc_neg   <= 1'b0;
            ovf       <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (step) begin
                acc_q    <= {r, acc_q[W-1:1]};
                op_r     <= op_cur;
                carry    <= carry_out;
                zero_run <= zero_cur & ~r;
                if (start && (state == RUN)) begin
                    sync_err <= 1'b1;
                end
                if (last) begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                    acc_neg   <= r;
                    acc_zero  <= zero_cur & ~r;
                    ovf       <= ((op_cur == ACC_ADD) || (op_cur == ACC_SUB)) ? (carry_cur ^ carry_out) : 1'b0;
                end else begin
                    state   <= RUN;
                    bit_cnt <= cnt_cur + 1'b1;
                end
            end
        end
    end

    assign busy    = (state == RUN);
    assign ser_out = acc_q[0];

endmodule

// File: tb/tb_serial_accumulator.sv
// tb/tb_serial_accumulator.sv - self-checking bench for serial_accumulator
module tb_serial_accumulator;

    localparam int         W       = 26;
    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_en;
    logic         word_start;
    logic [2:0]   op;
    logic         ser_in;
    logic         ser_out;
    logic [W-1:0] acc_q;
    logic         busy;
    logic         word_done;
    logic         acc_zero;
    logic         acc_neg;
    logic         ovf;
    logic         sync_err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_acc;
    logic         m_zero;
    logic         m_neg;
    logic         m_ovf;
    logic         m_serr;

    serial_accumulator #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .word_start (word_start),
        .op         (op),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .acc_q      (acc_q),
        .busy       (busy),
        .word_done  (word_done),
        .acc_zero   (acc_zero),
        .acc_neg    (acc_neg),
        .ovf        (ovf),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    function automatic void model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic ov);
        r  = a;
        ov = 1'b0;
        case (o)
            OP_LOAD: r = b;
            OP_ADD: begin
                r  = a + b;
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                r  = a - b;
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND:  r = a & b;
            default: r = a;
        endcase
    endfunction

    // Called at a negedge; leaves time at the following negedge.
    task automatic strobe(input logic ws, input logic [2:0] o, input logic b);
        bit_en     = 1'b1;
        word_start = ws;
        op         = o;
        ser_in     = b;
        @(negedge clk);
        bit_en     = 1'b0;
        word_start = 1'b0;
    endtask

    task automatic run_partial(input logic [2:0] o, input logic [W-1:0] b, input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmax, 0)) @(negedge clk);
            strobe(i == 0, o, b[i]);
            if (i < W - 1) begin
                total++;
                if (word_done !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL mid_word bit=%0d word_done=%b busy=%b required 0/1", i, word_done, busy);
                end
            end
        end
    endtask

    task automatic check_flags(input string tag);
        total++;
        if (acc_q !== m_acc || acc_zero !== m_zero || acc_neg !== m_neg || ovf !== m_ovf || sync_err !== m_serr) begin
            bad++;
            $display("FAIL %s acc_q=%h z=%b n=%b v=%b se=%b required acc_q=%h z=%b n=%b v=%b se=%b", tag,
                     acc_q, acc_zero, acc_neg, ovf, sync_err, m_acc, m_zero, m_neg, m_ovf, m_serr);
        end
    endtask

    task automatic run_word(input logic [2:0] o, input logic [W-1:0] b, input int gmax);
        logic [W-1:0] r;
        logic         ov;
        model_op(o, m_acc, b, r, ov);
        run_partial(o, b, W, gmax);
        m_acc  = r;
        m_zero = (r == '0);
        m_neg  = r[W-1];
        m_ovf  = ov;
        check_flags("word_result");
        total++;
        if (word_done !== 1'b1 || busy !== 1'b0 || ser_out !== r[0]) begin
            bad++;
            $display("FAIL word_done_pulse done=%b busy=%b ser_out=%b required 1/0/%b", word_done, busy, ser_out, r[0]);
        end
        @(negedge clk);
        total++;
        if (word_done !== 1'b0 || acc_q !== m_acc) begin
            bad++;
            $display("FAIL word_done_clear done=%b acc_q=%h required 0/%h", word_done, acc_q, m_acc);
        end
    endtask

    task automatic idle_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(1'b0, 3'($urandom_range(7, 0)), 1'($urandom));
            total++;
            if (acc_q !== m_acc || busy !== 1'b0 || word_done !== 1'b0) begin
                bad++;
                $display("FAIL idle_strobe acc_q=%h busy=%b done=%b required %h/0/0", acc_q, busy, word_done, m_acc);
            end
        end
    endtask

    task automatic model_reset();
        m_acc  = '0;
        m_zero = 1'b1;
        m_neg  = 1'b0;
        m_ovf  = 1'b0;
        m_serr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bit_en     = 1'b0;
        word_start = 1'b0;
        op         = OP_HOLD;
        ser_in     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_flags("reset_state");
        total++;
        if (busy !== 1'b0 || word_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl busy=%b done=%b required 0/0", busy, word_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_word(OP_LOAD, W'(5), 0);
        run_word(OP_ADD, W'(3), 0);
        total++;
        if (acc_q !== W'(8)) begin
            bad++;
            $display("FAIL add_const acc_q=%h required %h", acc_q, W'(8));
        end
    endtask

    task automatic test_sub();
        run_word(OP_LOAD, W'(3), 1);
        run_word(OP_SUB, W'(5), 1);
        total++;
        if (acc_q !== 26'h3FFFFFE || acc_neg !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL sub_neg acc_q=%h n=%b v=%b required 3fffffe/1/0", acc_q, acc_neg, ovf);
        end
        run_word(OP_SUB, 26'h3FFFFFE, 1);
        total++;
        if (acc_q !== '0 || acc_zero !== 1'b1) begin
            bad++;
            $display("FAIL sub_zero acc_q=%h z=%b required 0/1", acc_q, acc_zero);
        end
    endtask

    task automatic test_overflow();
        run_word(OP_LOAD, 26'h1FFFFFF, 0);
        run_word(OP_ADD, W'(1), 0);
        total++;
        if (acc_q !== 26'h2000000 || ovf !== 1'b1 || acc_neg !== 1'b1) begin
            bad++;
            $display("FAIL add_ovf acc_q=%h v=%b n=%b required 2000000/1/1", acc_q, ovf, acc_neg);
        end
        run_word(OP_AND, 26'h2000000, 0);
        total++;
        if (acc_q !== 26'h2000000 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL and_ovf_clear acc_q=%h v=%b required 2000000/0", acc_q, ovf);
        end
    endtask

    task automatic test_random_gaps();
        for (int k = 0; k < 24; k++) begin
            run_word(3'($urandom_range(7, 0)), W'($urandom), 5);
            idle_strobes($urandom_range(3, 0));
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
    endtask

    task automatic test_sync_err();
        logic [W-1:0] r;
        logic         ov;
        logic [W-1:0] b;
        b = W'($urandom);
        model_op(OP_ADD, m_acc, b, r, ov);
        run_partial(OP_ADD, b, 10, 2);
        m_acc = (m_acc >> 10) | (r << (W - 10));
        check_flags("abort_partial");
        m_serr = 1'b1;
        run_word(OP_SUB, W'($urandom), 2);
        // Restart on the final-bit strobe of a word: no completion for the abandoned word.
        b = W'($urandom);
        model_op(OP_AND, m_acc, b, r, ov);
        run_partial(OP_AND, b, W - 1, 1);
        m_acc = (m_acc >> (W - 1)) | (r << 1);
        check_flags("last_bit_partial");
        run_word(OP_ADD, W'($urandom), 1);
        total++;
        if (sync_err !== 1'b1) begin
            bad++;
            $display("FAIL sync_err_sticky sync_err=%b required 1", sync_err);
        end
    endtask

    task automatic test_reset_mid_word();
        run_word(OP_LOAD, W'($urandom), 0);
        run_partial(OP_SUB, W'($urandom), 13, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_flags("async_reset");
        total++;
        if (busy !== 1'b0 || word_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_ctrl busy=%b done=%b required 0/0", busy, word_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_word(OP_LOAD, 26'h155AA33, 1);
        run_word(OP_ADD, 26'h0000101, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_random_gaps();
        test_sync_err();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
